// File: rtl/adder4_bist_pkg.sv
// Shared types and constants for the 4-bit adder BIST engine.
// The top module honours the optional macro ADDER4_BIST_STOP_ON_FAIL_EN.
package adder4_bist_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StCheck  = 2'd2,
        StDone   = 2'd3
    } bist_state_e;

    localparam int unsigned NUM_VECTORS = 256;
    localparam logic [7:0]  LAST_IDX    = 8'hFF;

endpackage

// File: rtl/adder4_golden.sv
// Combinational reference model of a 4-bit adder with carry-out and signed overflow.
module adder4_golden (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] sum,
    output logic       carryout,
    output logic       overflow
);

    logic [4:0] full;

    assign full     = {1'b0, a} + {1'b0, b};
    assign sum      = full[3:0];
    assign carryout = full[4];
    // Signed overflow: like-signed operands producing a differently-signed result.
    assign overflow = (a[3] == b[3]) && (full[3] != a[3]);

endmodule

// File: rtl/adder4_bist.sv
// Exhaustive stimulus/response BIST for a 4-bit adder: sweeps all 256 operand pairs.
// Optional macro ADDER4_BIST_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module adder4_bist
    import adder4_bist_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned ERR_W         = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [3:0]       dut_a,
    output logic [3:0]       dut_b,
    input  logic [3:0]       dut_sum,
    input  logic             dut_carryout,
    input  logic             dut_overflow,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [3:0]       fail_a,
    output logic [3:0]       fail_b
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    bist_state_e      state_q, state_d;
    logic [7:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             fv_q, fv_d;
    logic [3:0]       fa_q, fa_d;
    logic [3:0]       fb_q, fb_d;

    logic [3:0] g_sum;
    logic       g_co;
    logic       g_of;
    logic       mismatch;
    logic       stop_now;

    adder4_golden u_golden (
        .a        (idx_q[7:4]),
        .b        (idx_q[3:0]),
        .sum      (g_sum),
        .carryout (g_co),
        .overflow (g_of)
    );

    assign mismatch = {dut_carryout, dut_sum, dut_overflow} != {g_co, g_sum, g_of};

`ifdef ADDER4_BIST_STOP_ON_FAIL_EN
    assign stop_now = (idx_q == LAST_IDX) || mismatch;
`else
    assign stop_now = (idx_q == LAST_IDX);
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fv_d    = fv_q;
        fa_d    = fa_q;
        fb_d    = fb_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    idx_d   = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    fv_d    = 1'b0;
                    fa_d    = '0;
                    fb_d    = '0;
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = StCheck;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StCheck: begin
                if (mismatch) begin
                    if (err_q != '1) begin
                        err_d = err_q + 1'b1;
                    end
                    if (!fv_q) begin
                        fv_d = 1'b1;
                        fa_d = idx_q[7:4];
                        fb_d = idx_q[3:0];
                    end
                end
                if (stop_now) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    cnt_d   = '0;
                    state_d = StSettle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            fa_q    <= '0;
            fb_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            fa_q    <= fa_d;
            fb_q    <= fb_d;
        end
    end

    // All outputs are decoded straight from flops, so nothing combinational reaches a port.
    assign dut_a      = idx_q[7:4];
    assign dut_b      = idx_q[3:0];
    assign busy       = (state_q == StSettle) || (state_q == StCheck);
    assign done       = (state_q == StDone);
    assign pass       = done && (err_q == '0);
    assign err_count  = err_q;
    assign fail_valid = fv_q;
    assign fail_a     = fa_q;
    assign fail_b     = fb_q;

endmodule

// File: tb/tb_adder4_bist.sv
// Directed bench for adder4_bist: drives a behavioural adder with selectable faults.
module tb_adder4_bist;

    localparam int unsigned ERR_W = 9;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [3:0]       dut_a;
    logic [3:0]       dut_b;
    logic [3:0]       dut_sum;
    logic             dut_carryout;
    logic             dut_overflow;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic             fail_valid;
    logic [3:0]       fail_a;
    logic [3:0]       fail_b;

    int checks;
    int errors;
    int fault_mode;  // 0 good, 1 overflow stuck at 0, 2 carry-out inverted
    int edges;

    adder4_bist #(
        .SETTLE_CYCLES (2),
        .ERR_W         (ERR_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .dut_a        (dut_a),
        .dut_b        (dut_b),
        .dut_sum      (dut_sum),
        .dut_carryout (dut_carryout),
        .dut_overflow (dut_overflow),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .err_count    (err_count),
        .fail_valid   (fail_valid),
        .fail_a       (fail_a),
        .fail_b       (fail_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder under test, written independently of the golden sub-module.
    logic [4:0] raw;
    always_comb begin
        raw          = {1'b0, dut_a} + {1'b0, dut_b};
        dut_sum      = raw[3:0];
        dut_carryout = raw[4];
        dut_overflow = (dut_a[3] & dut_b[3] & ~raw[3]) | (~dut_a[3] & ~dut_b[3] & raw[3]);
        if (fault_mode == 1) dut_overflow = 1'b0;
        if (fault_mode == 2) dut_carryout = ~raw[4];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulses start, then counts edges after the sampling edge until done; optionally
    // re-pulses start mid-sweep at edge inject_at.
    task automatic run_sweep(input int inject_at, output int n);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (!done && n < 3000) begin
            @(posedge clk);
            n++;
            #1;
            start = (n == inject_at);
        end
        start = 1'b0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        fault_mode = 0;
        start      = 1'b0;
        rst_n      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {dut_a, dut_b, busy, done, pass, err_count, fail_valid,
                                fail_a, fail_b}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Clean sweep.
        run_sweep(-1, edges);
        check("good_done_edge", edges, 768);
        check("good_err", err_count, 0);
        check("good_pass", pass, 1);
        check("good_fail_valid", fail_valid, 0);
        check("good_final_ops", {dut_a, dut_b}, 8'hFF);
        check("good_busy", busy, 0);

`ifdef ADDER4_BIST_STOP_ON_FAIL_EN
        fault_mode = 1;
        run_sweep(-1, edges);
        check("ovf_stop_edge", edges, 72);
        check("ovf_stop_err", err_count, 1);
        check("ovf_stop_fail", {fail_valid, fail_a, fail_b}, {1'b1, 4'h1, 4'h7});
        check("ovf_stop_pass", pass, 0);

        fault_mode = 2;
        run_sweep(-1, edges);
        check("co_stop_edge", edges, 3);
        check("co_stop_err", err_count, 1);
        check("co_stop_fail", {fail_valid, fail_a, fail_b}, {1'b1, 4'h0, 4'h0});
`else
        fault_mode = 1;
        run_sweep(-1, edges);
        check("ovf_edge", edges, 768);
        check("ovf_err", err_count, 64);
        check("ovf_fail", {fail_valid, fail_a, fail_b}, {1'b1, 4'h1, 4'h7});
        check("ovf_pass", pass, 0);

        fault_mode = 2;
        run_sweep(-1, edges);
        check("co_edge", edges, 768);
        check("co_err", err_count, 256);
        check("co_fail", {fail_valid, fail_a, fail_b}, {1'b1, 4'h0, 4'h0});
        check("co_pass", pass, 0);
`endif

        // Reset mid-sweep clears everything immediately and does not resume.
        fault_mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(posedge clk);
        #2;
        check("midsweep_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {dut_a, dut_b, busy, done, pass, err_count, fail_valid,
                                      fail_a, fail_b}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("no_resume_busy", {busy, done}, 2'b00);
        run_sweep(-1, edges);
        check("post_reset_edge", edges, 768);
        check("post_reset_pass", pass, 1);

        // start while busy is ignored.
        run_sweep(50, edges);
        check("busy_start_edge", edges, 768);
        check("busy_start_pass", {pass, err_count}, {1'b1, 9'd0});

        // start in DONE restarts and clears results.
        fault_mode = 1;
        run_sweep(-1, edges);
        check("done_pre_err_nonzero", (err_count != 0), 1);
        fault_mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("restart_state", {done, busy, fail_valid, err_count}, {1'b0, 1'b1, 1'b0, 9'd0});
        edges = 0;
        while (!done && edges < 3000) begin
            @(posedge clk);
            edges++;
            #1;
        end
        check("restart_edge", edges, 768);
        check("restart_pass", pass, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
